// File: rtl/pw_bend_scheduler.sv
// Pitch-bend scheduler: walks dirty voices through one shared multiplier
// and writes base_inc * bend_factor into the voice increment registers.
module pw_bend_scheduler #(
   parameter int NUM_VOICES = 8,
   parameter int VA_W       = 3,
   parameter int INC_W      = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [13:0]       pw_in,
   input  logic              pw_stb,
   input  logic              note_stb,
   input  logic [VA_W-1:0]   note_voice,
   output logic [13:0]       pw_out,
   input  logic [17:0]       factor_in,
   output logic [VA_W-1:0]   base_addr,
   input  logic [INC_W-1:0]  base_data,
   output logic [VA_W-1:0]   inc_addr,
   output logic [INC_W-1:0]  inc_out,
   output logic              inc_we,
   output logic              busy
);

   localparam int PROD_W = INC_W + 18;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_MULT,
      S_WRITE
   } state_t;

   state_t                state_q, state_d;
   logic [13:0]           pw_q, pw_d;
   logic [NUM_VOICES-1:0] dirty_q, dirty_d;
   logic [VA_W-1:0]       base_addr_q, base_addr_d;
   logic [VA_W-1:0]       inc_addr_q, inc_addr_d;
   logic [INC_W-1:0]      inc_out_q, inc_out_d;
   logic                  inc_we_q, inc_we_d;
   logic                  busy_q, busy_d;

   logic [NUM_VOICES-1:0] set_mask;
   logic [NUM_VOICES-1:0] clr_mask;
   logic [VA_W-1:0]       sel_idx;
   logic [PROD_W-1:0]     prod;
   logic [INC_W-1:0]      prod_sat;

   // Strobes that would mark a voice dirty this cycle; out-of-range notes drop out
   always_comb begin
      set_mask = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (pw_stb) set_mask[i] = 1'b1;
         if (note_stb && note_voice == VA_W'(i)) set_mask[i] = 1'b1;
      end
   end

   // Lowest-index dirty voice wins the next slot
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (dirty_q[i]) sel_idx = VA_W'(i);
      end
   end

   // Shared multiplier; base_data and factor are both stable through MULT
   always_comb begin
      prod = PROD_W'(base_data) * PROD_W'(factor_in);
      if (prod[PROD_W-1:INC_W+16] == '0) prod_sat = prod[INC_W+15:16];
      else prod_sat = '1;
   end

   // Next-state logic for the voice sequencer and its registered outputs
   always_comb begin
      state_d     = state_q;
      pw_d        = pw_stb ? pw_in : pw_q;
      base_addr_d = base_addr_q;
      inc_addr_d  = inc_addr_q;
      inc_out_d   = inc_out_q;
      inc_we_d    = 1'b0;
      clr_mask    = '0;
      unique case (state_q)
         S_IDLE: begin
            if (|dirty_q) begin
               base_addr_d       = sel_idx;
               clr_mask[sel_idx] = 1'b1;
               state_d           = S_FETCH;
            end
         end
         S_FETCH: state_d = S_MULT;
         S_MULT: begin
            inc_addr_d = base_addr_q;
            inc_out_d  = prod_sat;
            inc_we_d   = 1'b1;
            state_d    = S_WRITE;
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // set after clear so a coincident strobe keeps the voice pending
      dirty_d = (dirty_q & ~clr_mask) | set_mask;
      busy_d  = (|dirty_d) | (state_d != S_IDLE);
   end

   // State register; reset aborts any sweep in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pw_q        <= 14'h2000;
         dirty_q     <= '0;
         base_addr_q <= '0;
         inc_addr_q  <= '0;
         inc_out_q   <= '0;
         inc_we_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pw_q        <= pw_d;
         dirty_q     <= dirty_d;
         base_addr_q <= base_addr_d;
         inc_addr_q  <= inc_addr_d;
         inc_out_q   <= inc_out_d;
         inc_we_q    <= inc_we_d;
         busy_q      <= busy_d;
      end
   end

   assign pw_out    = pw_q;
   assign base_addr = base_addr_q;
   assign inc_addr  = inc_addr_q;
   assign inc_out   = inc_out_q;
   assign inc_we    = inc_we_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_pw_bend_scheduler.sv
// Bench for pw_bend_scheduler: directed timing cases plus a random
// strobe storm, checked against an arithmetic model of the bend rules.
module tb_pw_bend_scheduler;

   localparam int NV = 8;
   localparam int VA = 3;
   localparam int IW = 24;
   localparam int HIST = 30000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [13:0]   pw_in = '0;
   logic          pw_stb = 1'b0;
   logic          note_stb = 1'b0;
   logic [VA-1:0] note_voice = '0;
   logic [13:0]   pw_out;
   logic [17:0]   factor_in;
   logic [VA-1:0] base_addr;
   logic [IW-1:0] base_data = '0;
   logic [VA-1:0] inc_addr;
   logic [IW-1:0] inc_out;
   logic          inc_we;
   logic          busy;

   pw_bend_scheduler #(.NUM_VOICES(NV), .VA_W(VA), .INC_W(IW)) dut (
      .clk(clk), .reset(reset), .pw_in(pw_in), .pw_stb(pw_stb),
      .note_stb(note_stb), .note_voice(note_voice), .pw_out(pw_out),
      .factor_in(factor_in), .base_addr(base_addr), .base_data(base_data),
      .inc_addr(inc_addr), .inc_out(inc_out), .inc_we(inc_we), .busy(busy)
   );

   always #5 clk = ~clk;

   // interpolator stand-in: factor = pw * 16, so pw 0x1000 is unity
   assign factor_in = {pw_out, 4'b0000};

   logic [IW-1:0] base_mem [NV];
   always @(posedge clk) base_data <= base_mem[base_addr];

   int            errs = 0;
   int            checks = 0;
   int            cyc = 0;
   logic          rst_s = 1'b1;
   logic [13:0]   pw_m = 14'h2000;
   logic [13:0]   pw_hist [HIST];
   int            wr_cyc [$];
   int            wr_addr [$];
   logic [IW-1:0] mirror [NV];

   function automatic logic [IW-1:0] expect_inc(input logic [IW-1:0] b,
                                                input logic [13:0] pw);
      longint unsigned p;
      p = longint'(b) * (longint'(pw) * 16);
      p = p >> 16;
      if (p > 64'h0000_0000_00FF_FFFF) return '1;
      return p[IW-1:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // model of the pitchwheel register, one update per clock edge
   always @(posedge clk) begin
      cyc++;
      rst_s = reset;
      if (reset) pw_m = 14'h2000;
      else if (pw_stb) pw_m = pw_in;
   end

   // observe the write port and the pitchwheel output mid-cycle
   always @(negedge clk) begin
      if (cyc < HIST) pw_hist[cyc] = pw_m;
      chk("pw_out", 64'(pw_out), 64'(pw_m));
      if (rst_s) begin
         chk("rst_outs", {busy, inc_we, base_addr, inc_addr, inc_out},
             64'h0);
      end
      if (inc_we === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(int'(inc_addr));
         mirror[inc_addr] = inc_out;
         if (cyc >= 1 && cyc < HIST)
            chk("wr_value", 64'(inc_out),
                64'(expect_inc(base_mem[inc_addr], pw_hist[cyc-1])));
      end
   end

   task automatic pw_strobe(input logic [13:0] v, output int t);
      pw_in = v;
      pw_stb = 1'b1;
      t = cyc;
      @(negedge clk);
      pw_stb = 1'b0;
   endtask

   task automatic note(input int v, output int t);
      note_voice = VA'(v);
      note_stb = 1'b1;
      t = cyc;
      @(negedge clk);
      note_stb = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output int fall);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      fall = cyc;
      chk("busy_drop_in_time", 64'(n < bound), 64'd1);
   endtask

   initial begin
      int t, t2, f;
      for (int i = 0; i < NV; i++) begin
         base_mem[i] = '0;
         mirror[i] = '0;
      end

      // power-on reset
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_busy", 64'(busy), 64'd0);
      end

      // unity bend, full sweep timing
      for (int i = 0; i < NV; i++) base_mem[i] = 24'h100000;
      wr_cyc.delete();
      wr_addr.delete();
      pw_strobe(14'h1000, t);
      wait_idle(100, f);
      chk("unity_count", 64'(wr_cyc.size()), 64'd8);
      for (int k = 0; k < NV; k++) begin
         if (k < wr_cyc.size()) begin
            chk("unity_addr", 64'(wr_addr[k]), 64'(k));
            chk("unity_cyc", 64'(wr_cyc[k]), 64'(t + 4 + 4 * k));
         end
         chk("unity_val", 64'(mirror[k]), 64'h100000);
      end
      chk("unity_busy_fall", 64'(f), 64'(t + 33));

      // reset held 3 cycles in the middle of a sweep
      pw_strobe(14'h1800, t);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      wr_cyc.delete();
      wr_addr.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("post_rst_busy", 64'(busy), 64'd0);
      end
      chk("post_rst_writes", 64'(wr_cyc.size()), 64'd0);

      // 2x bend with saturation
      base_mem[0] = 24'h400000;
      base_mem[1] = 24'hFFFFFF;
      for (int i = 2; i < NV; i++) base_mem[i] = IW'($urandom);
      wr_cyc.delete();
      wr_addr.delete();
      pw_strobe(14'h2000, t);
      wait_idle(100, f);
      chk("sat_count", 64'(wr_cyc.size()), 64'd8);
      chk("sat_v0", 64'(mirror[0]), 64'h800000);
      chk("sat_v1", 64'(mirror[1]), 64'hFFFFFF);

      // single note while idle
      wr_cyc.delete();
      wr_addr.delete();
      note(5, t);
      wait_idle(50, f);
      chk("note_count", 64'(wr_cyc.size()), 64'd1);
      if (wr_cyc.size() > 0) begin
         chk("note_addr", 64'(wr_addr[0]), 64'd5);
         chk("note_cyc", 64'(wr_cyc[0]), 64'(t + 4));
      end

      // second pitchwheel during voice 3's MULT cycle
      for (int i = 0; i < NV; i++) base_mem[i] = IW'($urandom);
      wr_cyc.delete();
      wr_addr.delete();
      pw_strobe(14'h0C00, t);
      repeat (14) @(negedge clk);
      pw_strobe(14'h2F00, t2);
      wait_idle(200, f);
      chk("restart_count", 64'(wr_cyc.size()), 64'd12);
      for (int k = 0; k < wr_addr.size() && k < 12; k++)
         chk("restart_addr", 64'(wr_addr[k]), 64'(k < 4 ? k : k - 4));
      for (int v = 0; v < NV; v++)
         chk("restart_final", 64'(mirror[v]),
             64'(expect_inc(base_mem[v], 14'h2F00)));

      // note strobe coinciding with the select of the same voice
      wr_cyc.delete();
      wr_addr.delete();
      note(2, t);
      note(2, t2);
      wait_idle(50, f);
      chk("setclr_count", 64'(wr_cyc.size()), 64'd2);
      if (wr_cyc.size() == 2) begin
         chk("setclr_addr0", 64'(wr_addr[0]), 64'd2);
         chk("setclr_addr1", 64'(wr_addr[1]), 64'd2);
         chk("setclr_cyc1", 64'(wr_cyc[1]), 64'(t + 8));
      end

      // random strobe storm; every write checked by the monitor
      for (int i = 0; i < NV; i++) base_mem[i] = IW'($urandom);
      pw_strobe(14'($urandom), t);
      for (int n = 0; n < 400; n++) begin
         pw_stb = ($urandom_range(0, 19) == 0);
         pw_in = 14'($urandom);
         note_stb = ($urandom_range(0, 7) == 0);
         note_voice = VA'($urandom_range(0, NV - 1));
         @(negedge clk);
      end
      pw_stb = 1'b0;
      note_stb = 1'b0;
      wait_idle(200, f);
      for (int v = 0; v < NV; v++)
         chk("rand_final", 64'(mirror[v]),
             64'(expect_inc(base_mem[v], pw_m)));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
